// File: rtl/edge_row_profiler.sv
// ============================================================================
// Module   : edge_row_profiler
// Purpose  : Binarises a filtered pixel stream against a per-frame threshold
//            and gathers per-frame edge pixel / edge row / edge band counts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_row_profiler #(
    parameter  int IMG_WIDTH     = 640,
    parameter  int IMG_HEIGHT    = 480,
    parameter  int W             = 8,
    parameter  int BAND_MIN_ROWS = 4,
    localparam int COL_W         = $clog2(IMG_WIDTH + 1),
    localparam int TOT_W         = $clog2(IMG_WIDTH * IMG_HEIGHT + 1),
    localparam int ROW_W         = $clog2(IMG_HEIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [W-1:0]     x_data,
    input  logic [W-1:0]     threshold,
    input  logic [COL_W-1:0] row_min,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [W-1:0]     y_data,
    output logic             frame_valid,
    output logic [TOT_W-1:0] edge_total,
    output logic [ROW_W-1:0] edge_rows,
    output logic [7:0]       band_count
);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] RUN_MAX    = ROW_W'(IMG_HEIGHT);
    localparam logic [ROW_W:0]   BAND_MIN_L = (ROW_W + 1)'(BAND_MIN_ROWS);

    logic [COL_W-1:0] col_q, col_d, row_cnt_q, row_cnt_d, rmin_q, rmin_d;
    logic [ROW_W-1:0] row_q, row_d, rows_acc_q, rows_acc_d, run_q, run_d;
    logic [TOT_W-1:0] tot_acc_q, tot_acc_d, edge_total_q, edge_total_d;
    logic [ROW_W-1:0] edge_rows_q, edge_rows_d;
    logic [7:0]       band_acc_q, band_acc_d, band_count_q, band_count_d;
    logic [W-1:0]     thr_q, thr_d, y_data_q, y_data_d;
    logic             y_valid_q, y_valid_d, frame_valid_q, frame_valid_d;

    logic             accept, first_px, row_end, frame_end, is_edge, edge_row, close_band;
    logic [W-1:0]     thr_eff;
    logic [COL_W-1:0] rmin_eff, row_cnt_inc;
    logic [TOT_W-1:0] tot_inc;
    logic [ROW_W-1:0] rows_inc, run_inc, run_close;
    logic [7:0]       band_new;

    assign x_ready   = !rst && (!y_valid_q || y_ready);
    assign accept    = x_valid && x_ready;
    assign first_px  = (col_q == '0) && (row_q == '0);
    assign row_end   = (col_q == COL_LAST);
    assign frame_end = row_end && (row_q == ROW_LAST);

    // Pixel (0,0) sees the live controls; the rest of the frame uses the latched copy.
    assign thr_eff  = first_px ? threshold : thr_q;
    assign rmin_eff = first_px ? row_min : rmin_q;
    assign is_edge  = (x_data >= thr_eff);

    assign row_cnt_inc = row_cnt_q + COL_W'(is_edge);
    assign edge_row    = (row_cnt_inc >= rmin_eff);
    assign tot_inc     = tot_acc_q + TOT_W'(is_edge);
    assign rows_inc    = rows_acc_q + ROW_W'(edge_row);
    assign run_inc     = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    assign run_close   = edge_row ? run_inc : run_q;
    assign close_band  = ({1'b0, run_close} >= BAND_MIN_L);
    assign band_new    = (close_band && band_acc_q != 8'hFF) ? band_acc_q + 8'd1 : band_acc_q;

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        row_cnt_d     = row_cnt_q;
        thr_d         = thr_q;
        rmin_d        = rmin_q;
        tot_acc_d     = tot_acc_q;
        rows_acc_d    = rows_acc_q;
        run_d         = run_q;
        band_acc_d    = band_acc_q;
        y_valid_d     = y_valid_q;
        y_data_d      = y_data_q;
        frame_valid_d = 1'b0;
        edge_total_d  = edge_total_q;
        edge_rows_d   = edge_rows_q;
        band_count_d  = band_count_q;

        if (accept) begin
            y_valid_d = 1'b1;
            y_data_d  = is_edge ? '1 : '0;
            tot_acc_d = tot_inc;
            if (first_px) begin
                thr_d  = threshold;
                rmin_d = row_min;
            end
            if (row_end) begin
                col_d      = '0;
                row_cnt_d  = '0;
                row_d      = frame_end ? '0 : row_q + 1'b1;
                rows_acc_d = rows_inc;
                if (edge_row && !frame_end) begin
                    run_d = run_inc;
                end else begin
                    run_d      = '0;
                    band_acc_d = band_new;
                end
                if (frame_end) begin
                    edge_total_d  = tot_inc;
                    edge_rows_d   = rows_inc;
                    band_count_d  = band_new;
                    frame_valid_d = 1'b1;
                    tot_acc_d     = '0;
                    rows_acc_d    = '0;
                    band_acc_d    = '0;
                end
            end else begin
                col_d     = col_q + 1'b1;
                row_cnt_d = row_cnt_inc;
            end
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            row_cnt_q     <= '0;
            thr_q         <= '0;
            rmin_q        <= '0;
            tot_acc_q     <= '0;
            rows_acc_q    <= '0;
            run_q         <= '0;
            band_acc_q    <= '0;
            y_valid_q     <= 1'b0;
            y_data_q      <= '0;
            frame_valid_q <= 1'b0;
            edge_total_q  <= '0;
            edge_rows_q   <= '0;
            band_count_q  <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            row_cnt_q     <= row_cnt_d;
            thr_q         <= thr_d;
            rmin_q        <= rmin_d;
            tot_acc_q     <= tot_acc_d;
            rows_acc_q    <= rows_acc_d;
            run_q         <= run_d;
            band_acc_q    <= band_acc_d;
            y_valid_q     <= y_valid_d;
            y_data_q      <= y_data_d;
            frame_valid_q <= frame_valid_d;
            edge_total_q  <= edge_total_d;
            edge_rows_q   <= edge_rows_d;
            band_count_q  <= band_count_d;
        end
    end

    assign y_valid     = y_valid_q;
    assign y_data      = y_data_q;
    assign frame_valid = frame_valid_q;
    assign edge_total  = edge_total_q;
    assign edge_rows   = edge_rows_q;
    assign band_count  = band_count_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_row_profiler.sv
// ============================================================================
// Module   : tb_edge_row_profiler
// Purpose  : Scoreboard bench for edge_row_profiler on an 8x6 image.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_edge_row_profiler;

    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int NPIX = IW * IH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic [7:0] x_data = '0;
    logic [7:0] threshold = '0;
    logic [3:0] row_min = '0;
    logic       y_valid;
    logic       y_ready = 1'b1;
    logic [7:0] y_data;
    logic       frame_valid;
    logic [5:0] edge_total;
    logic [2:0] edge_rows;
    logic [7:0] band_count;

    edge_row_profiler #(
        .IMG_WIDTH    (IW),
        .IMG_HEIGHT   (IH),
        .W            (8),
        .BAND_MIN_ROWS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .threshold  (threshold),
        .row_min    (row_min),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .frame_valid(frame_valid),
        .edge_total (edge_total),
        .edge_rows  (edge_rows),
        .band_count (band_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          out_cnt = 0;
    int          fv_cnt = 0;
    bit          rdy_mode = 1'b0;
    logic [7:0]  exp_y[$];
    logic [31:0] exp_s[$];
    logic [7:0]  pix[NPIX];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic finish_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Row-by-row reference of the frame statistics, packed {total, rows, bands}.
    function automatic logic [31:0] model(input logic [7:0] thr, input int rmin);
        int tot = 0, rows = 0, band = 0, run = 0;
        for (int r = 0; r < IH; r++) begin
            int cnt = 0;
            for (int c = 0; c < IW; c++) if (pix[r*IW+c] >= thr) cnt++;
            tot += cnt;
            if (cnt >= rmin) begin
                rows++;
                run++;
            end else begin
                if (run >= 4 && band < 255) band++;
                run = 0;
            end
        end
        if (run >= 4 && band < 255) band++;
        return {16'(tot), 8'(rows), 8'(band)};
    endfunction

    task automatic fill_rows(input logic [5:0] mask);
        for (int i = 0; i < NPIX; i++) pix[i] = mask[i/IW] ? 8'hFF : 8'h00;
    endtask

    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            y_ready = !rdy_mode || (cyc % 4 == 0) || (cyc % 4 == 3);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("x_ready", 32'(x_ready), 32'(!(y_valid && !y_ready)));
            if (y_valid && y_ready) begin
                out_cnt++;
                if (exp_y.size() == 0) chk("y_unexpected", 32'(y_data), 32'hDEAD);
                else chk("y_data", 32'(y_data), 32'(exp_y.pop_front()));
            end
            if (frame_valid) begin
                fv_cnt++;
                if (exp_s.size() == 0) chk("fv_unexpected", 32'(frame_valid), 32'd0);
                else begin
                    logic [31:0] s;
                    s = exp_s.pop_front();
                    chk("edge_total", 32'(edge_total), 32'(s[31:16]));
                    chk("edge_rows",  32'(edge_rows),  32'(s[15:8]));
                    chk("band_count", 32'(band_count), 32'(s[7:0]));
                end
            end
        end
    end

    task automatic send_px(input logic [7:0] d, input logic [7:0] thr, input bit last,
                           input logic [31:0] stats);
        x_valid = 1'b1;
        x_data  = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (x_ready) break;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                finish_up();
            end
        end
        exp_y.push_back((d >= thr) ? 8'hFF : 8'h00);
        if (last) exp_s.push_back(stats);
        @(posedge clk);
        #1;
    endtask

    // Mid-frame control changes are junk values that would alter every result if used.
    task automatic send_frame(input logic [7:0] thr, input logic [3:0] rmin, input int npx);
        logic [31:0] stats;
        stats     = model(thr, int'(rmin));
        threshold = thr;
        row_min   = rmin;
        for (int i = 0; i < npx; i++) begin
            send_px(pix[i], thr, i == NPIX - 1, stats);
            if (i == 0) begin
                threshold = 8'h00;
                row_min   = 4'd0;
            end
        end
    endtask

    task automatic drain();
        x_valid = 1'b0;
        for (int n = 0; n <= 300; n++) begin
            @(negedge clk);
            if (exp_y.size() == 0 && exp_s.size() == 0) break;
            if (n == 300) chk("drain_timeout", 32'd0, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_x_ready",     32'(x_ready),     32'd0);
        chk("rst_y_valid",     32'(y_valid),     32'd0);
        chk("rst_y_data",      32'(y_data),      32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_edge_total",  32'(edge_total),  32'd0);
        chk("rst_edge_rows",   32'(edge_rows),   32'd0);
        chk("rst_band_count",  32'(band_count),  32'd0);
    endtask

    task automatic run_frames(input logic [5:0] m0, input logic [5:0] m1, input int nfr,
                              input logic [7:0] thr, input logic [3:0] rmin);
        int ob, fb;
        ob = out_cnt;
        fb = fv_cnt;
        fill_rows(m0);
        send_frame(thr, rmin, NPIX);
        if (nfr > 1) begin
            fill_rows(m1);
            send_frame(thr, rmin, NPIX);
        end
        drain();
        chk("out_count", 32'(out_cnt - ob), 32'(nfr * NPIX));
        chk("fv_count",  32'(fv_cnt - fb),  32'(nfr));
    endtask

    initial begin
        int ob, fb;
        repeat (3) @(posedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frames(6'b000000, 6'b0, 1, 8'h80, 4'd8);
        run_frames(6'b011110, 6'b0, 1, 8'h80, 4'd8);

        // Threshold boundary and a 7-edge row that falls short of row_min.
        begin
            ob = out_cnt;
            fb = fv_cnt;
            fill_rows(6'b0);
            for (int c = 0; c < IW; c++) begin
                pix[c]        = (c < 7) ? 8'h80 : 8'h7F;
                pix[IW + c]   = 8'h80;
                pix[2*IW + c] = c[0] ? 8'h7F : 8'h80;
            end
            send_frame(8'h80, 4'd8, NPIX);
            drain();
            chk("out_count", 32'(out_cnt - ob), 32'(NPIX));
            chk("fv_count",  32'(fv_cnt - fb),  32'd1);
        end

        run_frames(6'b111000, 6'b111100, 2, 8'h80, 4'd8);

        // Stalling consumer with random data.
        rdy_mode = 1'b1;
        begin
            ob = out_cnt;
            fb = fv_cnt;
            for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
            send_frame(8'h80, 4'd4, NPIX);
            drain();
            chk("out_count", 32'(out_cnt - ob), 32'(NPIX));
            chk("fv_count",  32'(fv_cnt - fb),  32'd1);
        end
        rdy_mode = 1'b0;

        // Partial frame discarded by reset.
        fill_rows(6'b011110);
        send_frame(8'h80, 4'd8, 20);
        drain();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frames(6'b011110, 6'b0, 1, 8'h80, 4'd8);

        finish_up();
    end

endmodule

`default_nettype wire
